// File: rtl/shift_sequencer_pkg.sv
// shift_sequencer_pkg: shared FSM state encodings and shift-direction codes.
package shift_sequencer_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;
endpackage

// File: rtl/sr_datapath.sv
// sr_datapath: N-bit bidirectional shift register with parallel load and serial-out capture.
module sr_datapath
  import shift_sequencer_pkg::*;
#(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift_en,
  input  logic         dir,
  input  logic         ser_in,
  input  logic [N-1:0] load_data,
  output logic [N-1:0] q,
  output logic         ser_out
);
  logic [N-1:0] q_q, q_d;
  logic         so_q, so_d;
  always_comb begin
    q_d  = load ? load_data
         : shift_en ? (dir == DIR_RIGHT ? {ser_in, q_q[N-1:1]} : {q_q[N-2:0], ser_in})
         : q_q;
    so_d = (!load && shift_en) ? (dir == DIR_LEFT ? q_q[N-1] : q_q[0]) : so_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q  <= '0;
      so_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      so_q <= so_d;
    end
  end
  assign q       = q_q;
  assign ser_out = so_q;
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: start/busy/done controller running an exact, clamped number of shifts.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int N     = 6,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] count,
  input  logic [N-1:0]     load_data,
  input  logic             ser_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [N-1:0]     data_out,
  output logic             ser_out
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, k;
  logic             dir_q, dir_d, err_q, err_d, over, load, shift_en;
  always_comb begin
    over     = count > CNT_W'(N);
    k        = over ? CNT_W'(N) : count;
    load     = state_q == ST_IDLE && start;
    shift_en = state_q == ST_SHIFT;
    state_d  = state_q == ST_IDLE  ? (start ? (k != '0 ? ST_SHIFT : ST_DONE) : ST_IDLE)
             : state_q == ST_SHIFT ? (cnt_q == CNT_W'(1) ? ST_DONE : ST_SHIFT)
             : ST_IDLE;
    // the count guard keeps cnt from wrapping even if SHIFT were entered with zero
    cnt_d    = load ? k : (shift_en && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    dir_d    = load ? dir : dir_q;
    err_d    = load ? over : err_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_RIGHT;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end
  assign busy = state_q != ST_IDLE;
  assign done = state_q == ST_DONE;
  assign err  = done && err_q;
  sr_datapath #(.N(N)) u_dp (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .shift_en  (shift_en),
    .dir       (dir_q),
    .ser_in    (ser_in),
    .load_data (load_data),
    .q         (data_out),
    .ser_out   (ser_out)
  );
endmodule
